sequential_shifter_right: RTL and testbench
===========================================

// Module: sequential_shifter_right
// PURPOSE
//  Multi-cycle right shifter (logical SRL / arithmetic SRA) for the RISC-V datapath.
//  Counterpart of the fixed left shifters: one power-of-two stage applied per clock,
//  so a full variable shift uses a single stage register instead of a combinational barrel.
//  Sits beside the ALU; the controller starts it with a start/ready handshake and collects
//  the result with a valid/ack handshake.
// PARAMETERS
//  NB_BITS_DATA   32                      data width; power of two, >= 2
//  NB_BITS_SHAMT  $clog2(NB_BITS_DATA)    shift-amount width; also the number of stages
// PORTS
//  clk_i     in   1              clock, rising edge
//  rst_n_i   in   1              synchronous reset, active low
//  start_i   in   1              request; accepted only when ready_o=1
//  data_i    in   NB_BITS_DATA   operand, sampled on accept
//  shamt_i   in   NB_BITS_SHAMT  shift amount, sampled on accept
//  arith_i   in   1              1=SRA (sign fill), 0=SRL (zero fill); sampled on accept
//  ready_o   out  1              1 in IDLE only
//  valid_o   out  1              result valid; 1 in DONE only
//  data_o    out  NB_BITS_DATA   result register; meaningful only while valid_o=1
//  ack_i     in   1              consumer takes result; meaningful only while valid_o=1
// BEHAVIOUR
//  - Reset (rst_n_i=0 at rising edge): state=IDLE, stage counter=0, data_o=0, ready_o=1,
//    valid_o=0. Applies from any state; in-flight operation is discarded, no result issued.
//  - FSM states IDLE, SHIFT, DONE. ready_o and valid_o decoded from state (registered).
//  - IDLE: start_i=1 at edge -> load work reg <= data_i, shamt reg <= shamt_i,
//    fill bit <= arith_i & data_i[NB_BITS_DATA-1], counter k <= 0, go SHIFT.
//    start_i=0 -> stay IDLE.
//  - SHIFT: each edge applies stage k: if shamt[k]=1, work <= {2^k fill bits, work[MSB:2^k]},
//    else work unchanged; k <= k+1. After stage NB_BITS_SHAMT-1 -> DONE.
//  - Latency fixed: accept at edge N, valid_o=1 after edge N+NB_BITS_SHAMT (5 for 32 bits),
//    independent of shamt (shamt=0 still takes full latency, returns data_i).
//  - DONE: valid_o=1, data_o stable. ack_i=1 at edge -> IDLE. No back-to-back accept:
//    start_i during DONE/SHIFT ignored (ready_o=0); earliest next accept one cycle after ack.
//  - Fill bit captured once at load; SRA of negative by max shamt gives all ones,
//    SRL by max shamt gives data_i>>(NB_BITS_DATA-1) (only MSB survives at bit 0).
//  - Inputs data_i/shamt_i/arith_i may change freely after accept; no effect on result.
//  - data_o = work register; holds last result in IDLE until next load (not cleared by ack).
//  - Counter width NB_BITS_SHAMT; must not wrap mid-operation (terminates on last stage).
// TESTING
//  1 SRL: data=0xF000_0000, shamt=4, arith=0 -> valid_o 5 cycles after accept, data_o=0x0F00_0000
//  2 SRA: data=0x8000_0000, shamt=31, arith=1 -> data_o=0xFFFF_FFFF; same with arith=0 -> 0x0000_0001
//  3 shamt=0: data=0x1234_5678, arith=1 -> data_o=0x1234_5678 after full 5-cycle latency
//  4 Handshake: hold ack_i=0 10 cycles -> valid_o stays 1, data_o stable, start_i ignored;
//    ack_i=1 -> IDLE next cycle, ready_o=1; change data_i after accept -> result unaffected
//  5 Reset mid-SHIFT (stage 2): rst_n_i=0 one edge -> ready_o=1, valid_o=0, data_o=0,
//    no valid_o pulse afterwards; new op after reset completes correctly
//  6 Random: 1000 ops, random data/shamt/arith and random ack delay -> data_o matches
//    >> / >>> reference model, latency always 5

Source files
------------

// File: rtl/sequential_shifter_right_if.sv
// Start/ready request and valid/ack result handshake between the datapath controller
// and the multi-cycle right shifter.
interface sequential_shifter_right_if #(
    parameter int NB_BITS_DATA  = 32,
    parameter int NB_BITS_SHAMT = $clog2(NB_BITS_DATA)
);
    logic                     start_i;
    logic [NB_BITS_DATA-1:0]  data_i;
    logic [NB_BITS_SHAMT-1:0] shamt_i;
    logic                     arith_i;
    logic                     ready_o;
    logic                     valid_o;
    logic [NB_BITS_DATA-1:0]  data_o;
    logic                     ack_i;

    modport master (
        output start_i, data_i, shamt_i, arith_i, ack_i,
        input  ready_o, valid_o, data_o
    );

    modport slave (
        input  start_i, data_i, shamt_i, arith_i, ack_i,
        output ready_o, valid_o, data_o
    );
endinterface

// File: rtl/sequential_shifter_right.sv
// Multi-cycle SRL/SRA: one power-of-two stage per clock through a single work register,
// fixed latency of NB_BITS_SHAMT cycles regardless of shift amount.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | ready for a request; data_o holds the previous result
// ST_SHIFT | applying stage k_q (shift by 2^k_q when shamt bit k_q is set)
// ST_DONE  | result valid, waiting for ack
module sequential_shifter_right #(
    parameter int NB_BITS_DATA  = 32,
    parameter int NB_BITS_SHAMT = $clog2(NB_BITS_DATA)
) (
    input logic                        clk_i,
    input logic                        rst_n_i,
    sequential_shifter_right_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [NB_BITS_SHAMT-1:0] K_LAST = NB_BITS_SHAMT'(NB_BITS_SHAMT - 1);

    logic [1:0]                state_q;
    logic [NB_BITS_DATA-1:0]   work_q;
    logic [NB_BITS_SHAMT-1:0]  shamt_q;
    logic [NB_BITS_SHAMT-1:0]  k_q;
    logic                      fill_q;

    // cand[g+1] is work_q shifted by stage g if that stage is the active, enabled one,
    // otherwise it passes cand[g] through; at most one stage matches k_q.
    logic [NB_BITS_SHAMT:0][NB_BITS_DATA-1:0] cand;

    assign cand[0] = work_q;

    for (genvar g = 0; g < NB_BITS_SHAMT; g++) begin : g_stage
        localparam int SH = 1 << g;
        logic [NB_BITS_DATA-1:0] shifted;
        logic                    sel;

        assign shifted    = {{SH{fill_q}}, work_q[NB_BITS_DATA-1:SH]};
        assign sel        = (k_q == NB_BITS_SHAMT'(g)) && shamt_q[g];
        assign cand[g+1]  = sel ? shifted : cand[g];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            shamt_q <= '0;
            k_q     <= '0;
            fill_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        work_q  <= bus.data_i;
                        shamt_q <= bus.shamt_i;
                        fill_q  <= bus.arith_i & bus.data_i[NB_BITS_DATA-1];
                        k_q     <= '0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    work_q <= cand[NB_BITS_SHAMT];
                    // Park the counter at zero on the last stage rather than wrapping.
                    if (k_q == K_LAST) begin
                        k_q     <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.ack_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    k_q     <= '0;
                end
            endcase
        end
    end

    assign bus.ready_o = (state_q == ST_IDLE);
    assign bus.valid_o = (state_q == ST_DONE);
    assign bus.data_o  = work_q;

endmodule

// File: tb/tb_sequential_shifter_right.sv
// Scoreboard bench for sequential_shifter_right: directed corner cases, handshake,
// mid-operation reset, then randomized traffic against a >> / >>> reference.
module tb_sequential_shifter_right;
    localparam int NB = 32;
    localparam int NS = 5;
    localparam int LAT = NS;
    localparam int N_RANDOM = 1000;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_sys = ~clk_sys;

    sequential_shifter_right_if #(.NB_BITS_DATA(NB), .NB_BITS_SHAMT(NS)) ifc ();

    sequential_shifter_right #(.NB_BITS_DATA(NB), .NB_BITS_SHAMT(NS)) dut (
        .clk_i   (clk_sys),
        .rst_n_i (rst_n),
        .bus     (ifc.slave)
    );

    typedef struct {
        logic [NB-1:0] res;
        int            acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic auto_ack = 1'b0;
    logic ack_auto = 1'b0;
    logic ack_man  = 1'b0;

    assign ifc.ack_i = ack_auto | ack_man;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [NB-1:0] ref_shift(input logic [NB-1:0] d, input int s, input logic a);
        if (a) return NB'($signed(d) >>> s);
        return d >> s;
    endfunction

    initial begin
        forever begin
            @(posedge clk_sys);
            cyc++;
        end
    end

    // Monitor: pops one expectation per result and checks value, latency and stability.
    initial begin
        logic          seen;
        logic [NB-1:0] hold;
        exp_t          e;
        seen = 1'b0;
        hold = '0;
        forever begin
            @(negedge clk_sys);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (ifc.valid_o) begin
                if (!seen) begin
                    seen = 1'b1;
                    hold = ifc.data_o;
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 64'(ifc.valid_o), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", 64'(ifc.data_o), 64'(e.res));
                        check("latency", 64'(cyc - e.acc_cyc), 64'(LAT));
                    end
                end else begin
                    check("data_o_stable", 64'(ifc.data_o), 64'(hold));
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    // Consumer with random ack delay, active only during randomized traffic.
    initial begin
        forever begin
            @(negedge clk_sys);
            if (auto_ack && rst_n && ifc.valid_o) begin
                repeat ($urandom_range(0, 3)) @(negedge clk_sys);
                ack_auto = 1'b1;
                @(negedge clk_sys);
                ack_auto = 1'b0;
            end
        end
    end

    task automatic issue(input logic [NB-1:0] d, input logic [NS-1:0] s, input logic a);
        exp_t e;
        int   n;
        n = 0;
        while (!ifc.ready_o && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        if (!ifc.ready_o) check("ready_timeout", 64'(ifc.ready_o), 64'd1);
        ifc.start_i = 1'b1;
        ifc.data_i  = d;
        ifc.shamt_i = s;
        ifc.arith_i = a;
        @(negedge clk_sys);
        e.res     = ref_shift(d, int'(s), a);
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        ifc.start_i = 1'b0;
        ifc.data_i  = NB'($urandom);
        ifc.shamt_i = NS'($urandom);
        ifc.arith_i = 1'($urandom);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!ifc.valid_o && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        if (!ifc.valid_o) check("valid_timeout", 64'(ifc.valid_o), 64'd1);
    endtask

    task automatic ack_now();
        ack_man = 1'b1;
        @(negedge clk_sys);
        ack_man = 1'b0;
    endtask

    logic [NB-1:0] dir_data [4] = '{32'hF000_0000, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
    logic [NS-1:0] dir_sh   [4] = '{5'd4, 5'd31, 5'd31, 5'd0};
    logic          dir_ar   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [NB-1:0] dir_res  [4] = '{32'h0F00_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h1234_5678};

    initial begin
        logic [NB-1:0] held;
        int n;
        ifc.start_i = 1'b0;
        ifc.data_i  = '0;
        ifc.shamt_i = '0;
        ifc.arith_i = 1'b0;

        repeat (2) @(negedge clk_sys);
        check("reset_ready", 64'(ifc.ready_o), 64'd1);
        check("reset_valid", 64'(ifc.valid_o), 64'd0);
        check("reset_data", 64'(ifc.data_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk_sys);

        for (int i = 0; i < 4; i++) begin
            issue(dir_data[i], dir_sh[i], dir_ar[i]);
            wait_valid();
            check("directed_value", 64'(ifc.data_o), 64'(dir_res[i]));
            ack_now();
        end

        // Hold off ack: result must persist, new starts must be ignored.
        issue(32'hA5A5_1234, 5'd7, 1'b1);
        wait_valid();
        held = ifc.data_o;
        check("hold_value", 64'(held), 64'(ref_shift(32'hA5A5_1234, 7, 1'b1)));
        for (int i = 0; i < 10; i++) begin
            ifc.start_i = 1'b1;
            ifc.data_i  = NB'($urandom);
            @(negedge clk_sys);
            check("hold_valid", 64'(ifc.valid_o), 64'd1);
            check("hold_ready", 64'(ifc.ready_o), 64'd0);
        end
        ifc.start_i = 1'b0;
        ack_now();
        check("after_ack_ready", 64'(ifc.ready_o), 64'd1);
        check("after_ack_valid", 64'(ifc.valid_o), 64'd0);
        check("after_ack_data_held", 64'(ifc.data_o), 64'(held));

        // Reset while stage 2 is pending; in-flight result is discarded.
        issue(32'hDEAD_BEEF, 5'd13, 1'b1);
        repeat (2) @(negedge clk_sys);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk_sys);
        rst_n = 1'b1;
        check("midreset_ready", 64'(ifc.ready_o), 64'd1);
        check("midreset_valid", 64'(ifc.valid_o), 64'd0);
        check("midreset_data", 64'(ifc.data_o), 64'd0);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_sys);
            if (ifc.valid_o) n++;
        end
        check("midreset_no_valid", 64'(n), 64'd0);
        issue(32'h8765_4321, 5'd9, 1'b1);
        wait_valid();
        check("post_reset_value", 64'(ifc.data_o), 64'hFFC3_B2A1);
        ack_now();

        auto_ack = 1'b1;
        for (int i = 0; i < N_RANDOM; i++) begin
            issue(NB'($urandom), NS'($urandom_range(0, NB - 1)), 1'($urandom));
        end

        n = 0;
        while ((exp_q.size() != 0 || !ifc.ready_o) && n < 100) begin
            @(negedge clk_sys);
            n++;
        end
        check("drain_queue", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
